// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one 32-bit logarithmic shifter, with a single registered response slot.
// Optional macro SHIFT_ARB_ROT_EN: op 11 rotates left; otherwise op 11 behaves as sll.

module shift_arb_shifter (
  input  logic [1:0]  op,
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic [31:0] res
);
  logic [5:0][31:0] st;
  logic right, fill;
`ifdef SHIFT_ARB_ROT_EN
  logic rot;
  assign rot = (op == 2'b11);
`endif

  assign right = (op == 2'b01) || (op == 2'b10);
  assign fill  = (op == 2'b10) && data[31];
  assign st[0] = data;

  // Stage s shifts by 16>>s when shamt[4-s] is set.
  for (genvar s = 0; s < 5; s++) begin : g_stg
    localparam int K = 16 >> s;
    logic [K-1:0] wrap;
`ifdef SHIFT_ARB_ROT_EN
    assign wrap = rot ? st[s][31 -: K] : '0;
`else
    assign wrap = '0;
`endif
    assign st[s+1] = !shamt[4-s] ? st[s] :
                     right       ? {{K{fill}}, st[s][31:K]} :
                                   {st[s][31-K:0], wrap};
  end

  assign res = st[5];
endmodule

module shift_arbiter #(
  parameter bit PRIO0_FIXED = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [15:0] xfer_count
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
  } sreq_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  sreq_t [NREQ-1:0] req;
  sreq_t            cur;
  logic [NREQ-1:0]  vld, win, rdy;
  logic             last_grant, slot_free, accept, sel;
  logic [31:0]      sh_res;
  state_t           state, state_nx;

  assign req[0] = {req0_op, req0_data, req0_shamt};
  assign req[1] = {req1_op, req1_data, req1_shamt};
  assign vld    = {req1_valid, req0_valid};

  // Requester 0 wins unless requester 1 alone is valid, or round-robin says it is 1's turn.
  always_comb begin
    win    = '0;
    win[0] = vld[0] && (!vld[1] || PRIO0_FIXED || last_grant);
    win[1] = vld[1] && !win[0];
  end

  assign slot_free  = (state == EMPTY) || rsp_ready;
  assign rdy        = win & {NREQ{slot_free}};
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign accept     = |rdy;
  assign sel        = win[1];
  assign cur        = req[sel];

  shift_arb_shifter u_shf (
    .op    (cur.op),
    .data  (cur.data),
    .shamt (cur.shamt),
    .res   (sh_res)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = FULL;
      FULL:    if (rsp_ready && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      xfer_count <= '0;
    end else if (accept) begin
      rsp_data   <= sh_res;
      rsp_id     <= sel;
      last_grant <= sel;
      xfer_count <= xfer_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized scoreboard bench for shift_arbiter: a predictor pushes expected results, a monitor pops them on drain.
module tb_shift_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        t_v   [2];
  logic [1:0]  t_op  [2];
  logic [31:0] t_data[2];
  logic [4:0]  t_sh  [2];
  logic        rsp_ready;
  logic        r0, r1, rsp_valid, rsp_id;
  logic [31:0] rsp_data;
  logic [15:0] xfer_count;

  logic        f_v, f_rr, f_r0, f_r1, f_rv, f_id;
  logic [31:0] f_data;
  logic [15:0] f_cnt;

  shift_arbiter #(.PRIO0_FIXED(1'b0)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(t_v[0]), .req0_ready(r0), .req0_op(t_op[0]), .req0_data(t_data[0]), .req0_shamt(t_sh[0]),
    .req1_valid(t_v[1]), .req1_ready(r1), .req1_op(t_op[1]), .req1_data(t_data[1]), .req1_shamt(t_sh[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .xfer_count(xfer_count)
  );

  shift_arbiter #(.PRIO0_FIXED(1'b1)) u_fix (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(f_v), .req0_ready(f_r0), .req0_op(2'b00), .req0_data(32'h0000_0001), .req0_shamt(5'd4),
    .req1_valid(f_v), .req1_ready(f_r1), .req1_op(2'b01), .req1_data(32'h0000_FFFF), .req1_shamt(5'd4),
    .rsp_valid(f_rv), .rsp_ready(f_rr), .rsp_id(f_id), .rsp_data(f_data), .xfer_count(f_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] d, logic [4:0] s);
    logic [63:0] w;
    w = {d, d} << s;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
`ifdef SHIFT_ARB_ROT_EN
      default: return w[63:32];
`else
      default: return d << s;
`endif
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic        sb_en = 1'b0;
  logic        m_full, m_last;
  logic [15:0] m_cnt;
  logic        acc[2];

  // Predictor: applies the grant rules to the current inputs and queues what the DUT must return.
  always @(negedge clock) begin : pred
    logic free, w0, w1, e0, e1, k;
    if (!sb_en) begin
      m_full = 1'b0; m_last = 1'b1; m_cnt = '0; q.delete();
      acc[0] = 1'b0; acc[1] = 1'b0;
    end else begin
      free = !m_full || rsp_ready;
      w0 = t_v[0] && (!t_v[1] || m_last);
      w1 = t_v[1] && !w0;
      e0 = w0 && free;
      e1 = w1 && free;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("req0_ready", 32'(r0), 32'(e0));
      chk("req1_ready", 32'(r1), 32'(e1));
      acc[0] = t_v[0] && r0;
      acc[1] = t_v[1] && r1;
      if (e0 || e1) begin
        k = e1;
        m_cnt = m_cnt + 16'd1;
        q.push_back('{id: k, data: ref_shift(t_op[k], t_data[k], t_sh[k]), cnt: m_cnt});
        m_last = k;
        m_full = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: whatever is held must match the oldest expectation; pop it on drain.
  always @(negedge clock) begin
    if (sb_en && rsp_valid) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid 1 expected no pending result at %0t", $time);
      end else begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", rsp_data, q[0].data);
        chk("xfer_count", 32'(xfer_count), 32'(q[0].cnt));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  // vmode: 0 random valid, 1 always valid; rmode: 0 random, 1 ready, 2 stalled.
  task automatic drive_cycles(int n, int vmode, int rmode);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      for (int k = 0; k < 2; k++) begin
        if (!t_v[k] || acc[k]) begin
          t_v[k]    = (vmode == 1) ? 1'b1 : ($urandom_range(0, 99) < 60);
          t_op[k]   = 2'($urandom_range(0, 3));
          t_data[k] = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 255))) : $urandom;
          t_sh[k]   = 5'($urandom_range(0, 31));
        end
      end
      rsp_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 99) < 70);
    end
  endtask

  task automatic issue(int k, logic [1:0] op, logic [31:0] d, logic [4:0] s);
    @(posedge clock); #1;
    t_op[k] = op; t_data[k] = d; t_sh[k] = s; t_v[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      if (acc[k]) break;
    end
    chk("issue_accept", 32'(acc[k]), 32'd1);
    #1 t_v[k] = 1'b0;
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 2; k++) begin
      t_v[k] = 1'b0; t_op[k] = '0; t_data[k] = '0; t_sh[k] = '0;
    end
    rsp_ready = 1'b1; f_v = 1'b0; f_rr = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_xfer_count", 32'(xfer_count), 32'd0);
    reset_n = 1'b1;
    sb_en = 1'b1;

    // Directed shifts from known operands.
    issue(0, 2'b00, 32'h0000_0001, 5'd31);
    chk("sll31_valid", 32'(rsp_valid), 32'd1);
    chk("sll31_id", 32'(rsp_id), 32'd0);
    chk("sll31_data", rsp_data, 32'h8000_0000);
    chk("sll31_count", 32'(xfer_count), 32'd1);
    issue(1, 2'b10, 32'h8000_00F0, 5'd4);
    chk("sra4_data", rsp_data, 32'hF800_000F);
    chk("sra4_id", 32'(rsp_id), 32'd1);
    issue(1, 2'b01, 32'h8000_00F0, 5'd4);
    chk("srl4_data", rsp_data, 32'h0800_000F);
    issue(1, 2'b10, 32'h8000_00F0, 5'd0);
    chk("sra0_data", rsp_data, 32'h8000_00F0);
    issue(0, 2'b11, 32'h8000_0001, 5'd1);
`ifdef SHIFT_ARB_ROT_EN
    chk("op3_data", rsp_data, 32'h0000_0003);
`else
    chk("op3_data", rsp_data, 32'h0000_0002);
`endif

    // Fixed-priority instance: requester 0 always wins under contention.
    @(posedge clock); #1 f_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("fix_req0_ready", 32'(f_r0), 32'd1);
      chk("fix_req1_ready", 32'(f_r1), 32'd0);
      if (f_rv) begin
        chk("fix_rsp_id", 32'(f_id), 32'd0);
        chk("fix_rsp_data", f_data, 32'h0000_0010);
      end
    end
    @(posedge clock); #1 f_v = 1'b0;
    chk("fix_count", 32'(f_cnt), 32'd10);

    // Continuous contention: one result per cycle, alternating ids.
    guard = 0;
    begin
      int a0;
      drive_cycles(1, 1, 1);
      a0 = 0;
      for (int i = 0; i < 8; i++) begin
        drive_cycles(1, 1, 1);
        if (acc[0] || acc[1]) a0++;
      end
      chk("rr_throughput", 32'(a0), 32'd8);
    end

    // Stall with result held, then drain and refill on the same edge.
    drive_cycles(4, 1, 2);
    drive_cycles(2, 1, 1);
    chk("drain_refill_valid", 32'(rsp_valid), 32'd1);

    drive_cycles(1500, 0, 0);

    // Run the counter round to zero.
    while (m_cnt != 16'd0 && guard < 70000) begin
      drive_cycles(1, 1, 1);
      guard++;
    end
    chk("wrap_guard", 32'(guard < 70000), 32'd1);
    chk("wrap_count", 32'(xfer_count), 32'd0);

    // Asynchronous reset while a result is held.
    t_v[0] = 1'b0; t_v[1] = 1'b0; rsp_ready = 1'b0;
    @(posedge clock); #3;
    chk("pre_reset_full", 32'(rsp_valid), 32'd1);
    sb_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_xfer_count", 32'(xfer_count), 32'd0);
    chk("async_rsp_data", rsp_data, 32'd0);
    chk("async_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clock);
    sb_en = 1'b1;

    // First contended cycle after reset goes to requester 0.
    drive_cycles(6, 1, 1);
    t_v[0] = 1'b0; t_v[1] = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit combinational logarithmic shifter (stages of 16/8/4/2/1 bits) between two requesters. In the processor, these are the ALU shift path (requester 0) and the board/graphics logic (requester 1). Each requester uses a valid/ready handshake, and a round-robin arbiter (optionally fixed-priority) picks the winner. The block registers one result and returns it on a shared response channel with backpressure. It sustains one shift per cycle when the response is drained every cycle.

## Interface
- PRIO0_FIXED, 0: 0 = round-robin; 1 = requester 0 always wins over requester 1.
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle when high with valid.
- req0_op / req1_op  input  2  00 sll, 01 srl, 10 sra, 11 see Configuration.
- req0_data / req1_data  input  32  operand.
- req0_shamt / req1_shamt  input  5  shift amount 0..31.
- rsp_valid  output  1  result register full.
- rsp_ready  input  1  consumer takes result when high with rsp_valid.
- rsp_id  output  1  requester that issued the held result.
- rsp_data  output  32  shifted result.
- xfer_count  output  16  accepted-request counter, wraps at 65535 -> 0.

## Operation
- Output slot is free when !rsp_valid || rsp_ready (drain and refill in the same cycle are allowed).
- Grant logic is combinational from req*_valid and last_grant.
  - Only one requester valid: it wins.
  - Both valid with PRIO0_FIXED=1: requester 0 wins.
  - Both valid with PRIO0_FIXED=0: the requester that was not last_grant wins.
- reqK_ready = winK && slot free. Ready may depend on valid; valid must never depend on ready. At most one ready is high per cycle.
- Requester holds op/data/shamt stable while valid && !ready.
- On accept:
  - rsp_data <= shift(op, data, shamt).
  - rsp_id <= K.
  - rsp_valid <= 1.
  - last_grant <= K.
  - xfer_count increments by 1.
- Drain without accept: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Two states:
  - EMPTY (rsp_valid=0): goes to FULL on accept.
  - FULL: stays FULL while stalled (!rsp_ready), and on drain+accept. Goes to EMPTY on drain with no accept.
- Shift rules:
  - sll and srl fill with zeros.
  - sra replicates bit 31.
  - shamt=0 passes the operand through unchanged.
  - shamt is unsigned and never wraps.

## Timing
- Latency: accept at edge N -> rsp_valid high after edge N; earliest drain at edge N+1.
- Throughput: one result per cycle while rsp_ready=1.
- A stalled result holds rsp_data/rsp_id stable until drained. Both readies stay low during the stall.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0, xfer_count=0.
  - last_grant=1, so requester 0 wins the first contended cycle.
  - req*_ready follow from valid inputs and may be high immediately after reset.
- Reset asserted mid-operation discards the held result and the counter at once, independent of clock.

## Configuration
- SHIFT_ARB_ROT_EN defined: op 11 = rotate left by shamt (bits shifted out of 31 re-enter at 0).
- SHIFT_ARB_ROT_EN undefined: op 11 is still accepted and behaves exactly as sll. The rotate path is not synthesized.

## Test plan
- Reset, then req0 sll data=0x0000_0001 shamt=31, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_id=0, rsp_data=0x8000_0000, xfer_count=1.
- req1 sra 0x8000_00F0 shamt=4 -> rsp_data=0xF800_000F; srl same operand -> 0x0800_000F; shamt=0 -> 0x8000_00F0.
- Both valid continuously, rsp_ready=1, PRIO0_FIXED=0 -> rsp_id sequence 0,1,0,1,…, one result per cycle. With PRIO0_FIXED=1 -> all 0, req1_ready never high.
- rsp_ready=0 for 3 cycles with a result held -> rsp_data/rsp_id stable, both readies low. rsp_ready=1 with req0 valid -> drain and accept on the same edge, rsp_valid stays 1.
- op 11 data=0x8000_0001 shamt=1 -> 0x0000_0003 with SHIFT_ARB_ROT_EN, 0x0000_0002 without.
- 65536 accepts -> xfer_count returns to 0. Assert reset_n low while FULL -> rsp_valid=0 and xfer_count=0 immediately, before the next clock edge.
